// File: rtl/ledseq_pkg.sv
// Shared types and step-code constants for the LED step sequencer.
// Pure declarations: no latency, no flow control.
package ledseq_pkg;

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int             STEP_W     = 4;
    localparam logic [STEP_W-1:0] STEP_BLANK = 4'd0;
    localparam logic [STEP_W-1:0] STEP_MIN   = 4'd1;
    localparam logic [STEP_W-1:0] STEP_MAX   = 4'd9;

endpackage

// File: rtl/led_step_seq_btn_debounce.sv
// Button conditioner: 2-flop sync, debounce counter, one-cycle press pulse on a debounced 1->0.
// Press appears DEBOUNCE_CYC+2 edges after btn_n is first sampled low; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 240_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != stable) begin
                if (cnt == CW'(DEBOUNCE_CYC)) begin
                    stable <= sync2;
                    cnt    <= '0;
                    // only the released->pressed transition is an event
                    press  <= stable;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_step_seq.sv
// Ping-pong 1..9 step generator with button run/pause; outputs registered, one step per prescaler period.
// Optional LEDSEQ_SPEED_EN adds a 2-bit speed input dividing the period (min 2); no backpressure.
module led_step_seq
    import ledseq_pkg::*;
#(
    parameter int TICK_DIV     = 12_000_000,
    parameter int DEBOUNCE_CYC = 240_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_n,
`ifdef LEDSEQ_SPEED_EN
    input  logic [1:0]        speed,
`endif
    output logic [STEP_W-1:0] step,
    output logic              running,
    output logic              dir,
    output logic              turn
);

    localparam int            PW          = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0] PERIOD_FULL = PW'(TICK_DIV);

    state_t              state_q, state_n;
    logic [PW-1:0]       presc_q, presc_n;
    logic [STEP_W-1:0]   step_q, step_n;
    logic                dir_q, dir_n;
    logic                turn_q, turn_n;
    logic [PW-1:0]       period_cur;
    logic                press;
    logic                tick;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n),
        .press (press)
    );

`ifdef LEDSEQ_SPEED_EN
    logic [PW-1:0] period_q;
    logic [PW-1:0] period_shift;
    logic [PW-1:0] period_smp;
    logic          restart;

    assign period_shift = PERIOD_FULL >> speed;
    assign period_smp   = (period_shift < PW'(2)) ? PW'(2) : period_shift;
    // speed is latched only when a new period begins, so mid-period changes wait a period
    assign restart      = ((state_q == PAUSE) && press) ||
                          ((state_q == RUN) && !press && tick);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_q <= PERIOD_FULL;
        end else if (restart) begin
            period_q <= period_smp;
        end
    end

    assign period_cur = period_q;
`else
    assign period_cur = PERIOD_FULL;
`endif

    assign tick = (state_q == RUN) && (presc_q == (period_cur - PW'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PAUSE;
            presc_q <= '0;
            step_q  <= STEP_BLANK;
            dir_q   <= 1'b0;
            turn_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            presc_q <= presc_n;
            step_q  <= step_n;
            dir_q   <= dir_n;
            turn_q  <= turn_n;
        end
    end

    always_comb begin
        state_n = state_q;
        presc_n = presc_q;
        step_n  = step_q;
        dir_n   = dir_q;
        turn_n  = 1'b0;
        case (state_q)
            PAUSE: begin
                presc_n = '0;
                if (press) begin
                    state_n = RUN;
                    if (step_q == STEP_BLANK) begin
                        step_n = STEP_MIN;
                    end
                end
            end
            RUN: begin
                // a press landing on a tick pauses without advancing the step
                if (press) begin
                    state_n = PAUSE;
                    presc_n = '0;
                end else if (tick) begin
                    presc_n = '0;
                    if (!dir_q) begin
                        if (step_q < STEP_MAX) begin
                            step_n = step_q + 4'd1;
                        end else begin
                            step_n = STEP_MAX - 4'd1;
                            dir_n  = 1'b1;
                            turn_n = 1'b1;
                        end
                    end else begin
                        if (step_q > STEP_MIN) begin
                            step_n = step_q - 4'd1;
                        end else begin
                            step_n = STEP_MIN + 4'd1;
                            dir_n  = 1'b0;
                            turn_n = 1'b1;
                        end
                    end
                end else begin
                    presc_n = presc_q + PW'(1);
                end
            end
            default: state_n = PAUSE;
        endcase
    end

    assign step    = step_q;
    assign running = (state_q == RUN);
    assign dir     = dir_q;
    assign turn    = turn_q;

endmodule

// File: tb/tb_led_step_seq.sv
// Directed bench for led_step_seq with TICK_DIV=4, DEBOUNCE_CYC=3.
module tb_led_step_seq;

    logic       clk;
    logic       rst_n;
    logic       btn_n;
    logic [3:0] step;
    logic       running;
    logic       dir;
    logic       turn;
`ifdef LEDSEQ_SPEED_EN
    logic [1:0] speed;
`endif

    int         n_cmp;
    int         n_mis;
    int         toggles;
    logic       prev_run;
    logic [3:0] prev_step;
    logic [5:0] exp_tbl [18];

    led_step_seq #(
        .TICK_DIV     (4),
        .DEBOUNCE_CYC (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n   (btn_n),
`ifdef LEDSEQ_SPEED_EN
        .speed   (speed),
`endif
        .step    (step),
        .running (running),
        .dir     (dir),
        .turn    (turn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        // {step, dir, turn} after each tick of the sweep, starting from step 1
        exp_tbl = '{
            {4'd2, 2'b00}, {4'd3, 2'b00}, {4'd4, 2'b00}, {4'd5, 2'b00},
            {4'd6, 2'b00}, {4'd7, 2'b00}, {4'd8, 2'b00}, {4'd9, 2'b00},
            {4'd8, 2'b11}, {4'd7, 2'b10}, {4'd6, 2'b10}, {4'd5, 2'b10},
            {4'd4, 2'b10}, {4'd3, 2'b10}, {4'd2, 2'b10}, {4'd1, 2'b10},
            {4'd2, 2'b01}, {4'd3, 2'b00}
        };
`ifdef LEDSEQ_SPEED_EN
        speed = 2'd0;
`endif
        rst_n = 1'b0;
        btn_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            cyc();
            chk("reset_outs", {step, running, dir, turn}, 7'h00);
        end
        btn_n = 1'b1;
        cyc();
        rst_n = 1'b1;
        repeat (5) cyc();
        chk("idle", {step, running, dir, turn}, 7'h00);

        // two-sample bounce must not register
        btn_n = 1'b0;
        cyc();
        cyc();
        btn_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("bounce_running", running, 1'b0);
        end
        chk("bounce_step", step, 4'd0);

        // first press: toggle lands on edge 6 after first low sample
        btn_n = 1'b0;
        repeat (6) cyc();
        chk("press_early", running, 1'b0);
        cyc();
        chk("press_edge6", {step, running, dir}, {4'd1, 1'b1, 1'b0});
        btn_n = 1'b1;

        prev_step = 4'd1;
        for (int t = 0; t < 18; t++) begin
            for (int k = 0; k < 3; k++) begin
                cyc();
                chk("between_ticks", {step, turn}, {prev_step, 1'b0});
            end
            cyc();
            chk("sweep", {step, dir, turn}, exp_tbl[t]);
            prev_step = exp_tbl[t][5:2];
        end

        // now just after a tick with step=3; align press with the 5->6 tick 12 edges later
        repeat (5) cyc();
        btn_n = 1'b0;
        repeat (6) cyc();
        chk("pre_pause", {step, running}, {4'd5, 1'b1});
        cyc();
        chk("pause_on_tick", {step, running, dir, turn}, {4'd5, 3'b000});
        btn_n = 1'b1;
        repeat (10) cyc();
        chk("pause_hold", {step, running}, {4'd5, 1'b0});

        btn_n = 1'b0;
        repeat (6) cyc();
        chk("resume_early", running, 1'b0);
        cyc();
        chk("resume", {step, running}, {4'd5, 1'b1});
        repeat (3) cyc();
        chk("resume_wait", step, 4'd5);
        cyc();
        chk("resume_step", {step, dir}, {4'd6, 1'b0});
        btn_n = 1'b1;
        repeat (10) cyc();

        // held button: exactly one toggle
        chk("held_start", running, 1'b1);
        btn_n = 1'b0;
        toggles = 0;
        prev_run = running;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (running !== prev_run) toggles++;
            prev_run = running;
            if (i == 6) chk("held_toggle_edge", running, 1'b0);
        end
        chk("held_toggles", toggles, 1);
        btn_n = 1'b1;
        repeat (10) cyc();
        chk("after_release", running, 1'b0);
        btn_n = 1'b0;
        repeat (7) cyc();
        chk("second_press", running, 1'b1);
        btn_n = 1'b1;
        repeat (5) cyc();

        rst_n = 1'b0;
        cyc();
        chk("reset_midrun", {step, running, dir, turn}, 7'h00);
        rst_n = 1'b1;
        repeat (5) cyc();

`ifdef LEDSEQ_SPEED_EN
        speed = 2'd1;
        btn_n = 1'b0;
        repeat (7) cyc();
        chk("spd_start", {step, running}, {4'd1, 1'b1});
        btn_n = 1'b1;
        repeat (2) cyc();
        chk("spd1_a", step, 4'd2);
        repeat (2) cyc();
        chk("spd1_b", step, 4'd3);
        speed = 2'd3;
        repeat (2) cyc();
        chk("spd3_a", step, 4'd4);
        repeat (2) cyc();
        chk("spd3_b", step, 4'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
